// File: rtl/frame_buffer_scheduler_pkg.sv
// Shared types, FSM encodings and defaults for the frame buffer scheduler.
// Build option FRAME_BUF_TRIPLE_EN selects three buffers instead of two.
package frame_buffer_scheduler_pkg;

`ifdef FRAME_BUF_TRIPLE_EN
  localparam int NUM_BUF = 3;
`else
  localparam int NUM_BUF = 2;
`endif

  localparam logic [31:0] BASE_ADDR_DEF    = 32'h0100_0000;
  localparam logic [31:0] FRAME_STRIDE_DEF = 32'h0002_5800;

  localparam logic [1:0] ST_DISABLED  = 2'd0;
  localparam logic [1:0] ST_RUN       = 2'd1;
  localparam logic [1:0] ST_SWAP_WAIT = 2'd2;

  typedef logic [1:0] buf_idx_t;

  localparam buf_idx_t RST_RD_IDX = buf_idx_t'(NUM_BUF - 1);

  typedef struct packed {
    logic        ok;
    buf_idx_t    idx;
  } pick_t;

  typedef struct packed {
    logic [1:0]  state;
    buf_idx_t    wr_idx;
    buf_idx_t    rd_idx;
    buf_idx_t    latest_idx;
    logic        latest_valid;
    buf_idx_t    pend_idx;
    logic        frame_ready;
    logic [15:0] drop_count;
  } sched_regs_t;

  localparam sched_regs_t SCHED_RST = '{
    state:        ST_DISABLED,
    wr_idx:       '0,
    rd_idx:       RST_RD_IDX,
    latest_idx:   '0,
    latest_valid: 1'b0,
    pend_idx:     '0,
    frame_ready:  1'b0,
    drop_count:   '0
  };

  // Lowest buffer index that neither the reader nor the
  // freshly completed frame occupies.
  function automatic pick_t pick_free(buf_idx_t rd, buf_idx_t lat);
    pick_t p;
    p.ok  = 1'b0;
    p.idx = '0;
    for (int i = NUM_BUF - 1; i >= 0; i--) begin
      buf_idx_t c;
      c = buf_idx_t'(i);
      if (c != rd && c != lat) begin
        p.ok  = 1'b1;
        p.idx = c;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/frame_buffer_scheduler_addr_calc.sv
// fb_addr_calc: registered buffer index -> DDR base address.
// Ports: clk_100Mhz, rst (async, high), idx in, addr out (AW bits).
module fb_addr_calc
  import frame_buffer_scheduler_pkg::*;
#(
  parameter int                AW      = 32,
  parameter logic [AW-1:0]     BASE    = BASE_ADDR_DEF,
  parameter logic [AW-1:0]     STRIDE  = FRAME_STRIDE_DEF,
  parameter logic [1:0]        RST_IDX = 2'd0
) (
  input  logic          clk_100Mhz,
  input  logic          rst,
  input  logic [1:0]    idx,
  output logic [AW-1:0] addr
);

  // Truncation to AW bits gives the modulo-2^AW wrap.
  function automatic logic [AW-1:0] calc(logic [1:0] i);
    logic [AW-1:0] ie;
    ie = AW'(i);
    return BASE + ie * STRIDE;
  endfunction

  always_ff @(posedge clk_100Mhz or posedge rst) begin
    if (rst) addr <= calc(RST_IDX);
    else     addr <= calc(idx);
  end

endmodule

// File: rtl/frame_buffer_scheduler.sv
// Frame buffer scheduler: hands writer/reader distinct DDR buffers.
// Ports: clk_100Mhz, rst (async, high), enable, wr_frame_done, wr_idle,
//   rd_vsync in; wr/rd base addr, wr/rd buf idx, frame_ready,
//   drop_count, sched_state out. Macro: FRAME_BUF_TRIPLE_EN (3 buffers).
module frame_buffer_scheduler
  import frame_buffer_scheduler_pkg::*;
#(
  parameter int                        AXI_ADDR_WIDTH = 32,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = BASE_ADDR_DEF,
  parameter logic [AXI_ADDR_WIDTH-1:0] FRAME_STRIDE   = FRAME_STRIDE_DEF
) (
  input  logic                      clk_100Mhz,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      wr_frame_done,
  input  logic                      wr_idle,
  input  logic                      rd_vsync,
  output logic [AXI_ADDR_WIDTH-1:0] wr_base_addr,
  output logic [AXI_ADDR_WIDTH-1:0] rd_base_addr,
  output logic [1:0]                wr_buf_idx,
  output logic [1:0]                rd_buf_idx,
  output logic                      frame_ready,
  output logic [15:0]               drop_count,
  output logic [1:0]                sched_state
);

  sched_regs_t q;
  sched_regs_t d;
  buf_idx_t    rd_nxt;
  pick_t       pk;
  logic [15:0] drop_inc;

  assign drop_inc = (q.drop_count == 16'hFFFF) ?
                    q.drop_count : q.drop_count + 16'd1;

  always_comb begin
    d      = q;
    rd_nxt = q.rd_idx;
    pk     = '0;
    if (!enable) begin
      // Leaving SWAP_WAIT here drops the pending swap.
      d.state = ST_DISABLED;
    end else begin
      // Reader moves first so the writer selects against it.
      if (q.state != ST_DISABLED && rd_vsync &&
          q.latest_valid && q.latest_idx != q.rd_idx)
        rd_nxt = q.latest_idx;
      pk = pick_free(rd_nxt, q.wr_idx);
      unique case (1'b1)
        (q.state == ST_DISABLED): begin
          d.state = ST_RUN;
        end
        (q.state == ST_RUN): begin
          if (wr_frame_done) begin
            d.latest_idx   = q.wr_idx;
            d.latest_valid = 1'b1;
            d.frame_ready  = 1'b1;
            if (!pk.ok) begin
              // Writer must overwrite the frame it just made.
              d.drop_count   = drop_inc;
              d.latest_valid = 1'b0;
            end else if (wr_idle) begin
              d.wr_idx = pk.idx;
            end else begin
              d.pend_idx = pk.idx;
              d.state    = ST_SWAP_WAIT;
            end
          end
        end
        (q.state == ST_SWAP_WAIT): begin
          if (wr_frame_done)
            d.drop_count = drop_inc;
          if (wr_idle) begin
            d.wr_idx = q.pend_idx;
            d.state  = ST_RUN;
          end
        end
        default: begin
          d.state = ST_DISABLED;
        end
      endcase
      d.rd_idx = rd_nxt;
    end
  end

  always_ff @(posedge clk_100Mhz or posedge rst) begin
    if (rst) q <= SCHED_RST;
    else     q <= d;
  end

  assign wr_buf_idx  = q.wr_idx;
  assign rd_buf_idx  = q.rd_idx;
  assign frame_ready = q.frame_ready;
  assign drop_count  = q.drop_count;
  assign sched_state = q.state;

  fb_addr_calc #(
    .AW      (AXI_ADDR_WIDTH),
    .BASE    (BASE_ADDR),
    .STRIDE  (FRAME_STRIDE),
    .RST_IDX (2'd0)
  ) u_wr_addr (
    .clk_100Mhz (clk_100Mhz),
    .rst        (rst),
    .idx        (q.wr_idx),
    .addr       (wr_base_addr)
  );

  fb_addr_calc #(
    .AW      (AXI_ADDR_WIDTH),
    .BASE    (BASE_ADDR),
    .STRIDE  (FRAME_STRIDE),
    .RST_IDX (RST_RD_IDX)
  ) u_rd_addr (
    .clk_100Mhz (clk_100Mhz),
    .rst        (rst),
    .idx        (q.rd_idx),
    .addr       (rd_base_addr)
  );

endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// Directed bench for frame_buffer_scheduler.
// Expectations follow the build (FRAME_BUF_TRIPLE_EN or not).
module tb_frame_buffer_scheduler;

  logic        clk_100Mhz = 1'b0;
  logic        rst;
  logic        enable;
  logic        wr_frame_done;
  logic        wr_idle;
  logic        rd_vsync;
  logic [31:0] wr_base_addr;
  logic [31:0] rd_base_addr;
  logic [1:0]  wr_buf_idx;
  logic [1:0]  rd_buf_idx;
  logic        frame_ready;
  logic [15:0] drop_count;
  logic [1:0]  sched_state;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk_100Mhz = ~clk_100Mhz;

  frame_buffer_scheduler dut (
    .clk_100Mhz    (clk_100Mhz),
    .rst           (rst),
    .enable        (enable),
    .wr_frame_done (wr_frame_done),
    .wr_idle       (wr_idle),
    .rd_vsync      (rd_vsync),
    .wr_base_addr  (wr_base_addr),
    .rd_base_addr  (rd_base_addr),
    .wr_buf_idx    (wr_buf_idx),
    .rd_buf_idx    (rd_buf_idx),
    .frame_ready   (frame_ready),
    .drop_count    (drop_count),
    .sched_state   (sched_state)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_100Mhz);
    #1;
  endtask

  task automatic pulse_done();
    wr_frame_done = 1'b1;
    tick();
    wr_frame_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    wr_frame_done = 1'b0;
    wr_idle = 1'b1;
    rd_vsync = 1'b0;
    tick();
    tick();
    chk("rst_state", 32'(sched_state), 32'd0);
    chk("rst_wr_idx", 32'(wr_buf_idx), 32'd0);
    chk("rst_wr_addr", wr_base_addr, 32'h0100_0000);
    chk("rst_drop", 32'(drop_count), 32'd0);
    chk("rst_ready", 32'(frame_ready), 32'd0);
`ifdef FRAME_BUF_TRIPLE_EN
    chk("rst_rd_idx", 32'(rd_buf_idx), 32'd2);
    chk("rst_rd_addr", rd_base_addr, 32'h0104_B000);
`else
    chk("rst_rd_idx", 32'(rd_buf_idx), 32'd1);
    chk("rst_rd_addr", rd_base_addr, 32'h0102_5800);
`endif
    rst = 1'b0;
    enable = 1'b1;
    tick();
    chk("en_state", 32'(sched_state), 32'd1);

`ifdef FRAME_BUF_TRIPLE_EN
    pulse_done();
    chk("sw_wr_idx", 32'(wr_buf_idx), 32'd1);
    chk("sw_ready", 32'(frame_ready), 32'd1);
    tick();
    chk("sw_wr_addr", wr_base_addr, 32'h0102_5800);

    rd_vsync = 1'b1;
    tick();
    rd_vsync = 1'b0;
    chk("vs_rd_idx", 32'(rd_buf_idx), 32'd0);
    tick();
    chk("vs_rd_addr", rd_base_addr, 32'h0100_0000);

    wr_idle = 1'b0;
    pulse_done();
    chk("wait_state", 32'(sched_state), 32'd2);
    chk("wait_wr_idx", 32'(wr_buf_idx), 32'd1);
    tick();
    tick();
    chk("wait_addr_hold", wr_base_addr, 32'h0102_5800);
    wr_idle = 1'b1;
    tick();
    chk("commit_wr_idx", 32'(wr_buf_idx), 32'd2);
    chk("commit_state", 32'(sched_state), 32'd1);
    tick();
    chk("commit_addr", wr_base_addr, 32'h0104_B000);

    rd_vsync = 1'b1;
    wr_frame_done = 1'b1;
    tick();
    rd_vsync = 1'b0;
    wr_frame_done = 1'b0;
    chk("sim_rd_idx", 32'(rd_buf_idx), 32'd1);
    chk("sim_wr_idx", 32'(wr_buf_idx), 32'd0);
    chk("sim_drop", 32'(drop_count), 32'd0);

    wr_idle = 1'b0;
    pulse_done();
    chk("w2_state", 32'(sched_state), 32'd2);
    pulse_done();
    chk("w2_drop", 32'(drop_count), 32'd1);
    chk("w2_wr_idx", 32'(wr_buf_idx), 32'd0);
    enable = 1'b0;
    tick();
    chk("dis_state", 32'(sched_state), 32'd0);
    wr_idle = 1'b1;
    tick();
    tick();
    chk("dis_wr_idx", 32'(wr_buf_idx), 32'd0);
    chk("dis_rd_idx", 32'(rd_buf_idx), 32'd1);
    chk("dis_wr_addr", wr_base_addr, 32'h0100_0000);
    chk("dis_rd_addr", rd_base_addr, 32'h0102_5800);
    enable = 1'b1;
    tick();
    chk("reen_state", 32'(sched_state), 32'd1);
    chk("reen_wr_idx", 32'(wr_buf_idx), 32'd0);

    wr_idle = 1'b0;
    pulse_done();
    chk("w3_state", 32'(sched_state), 32'd2);
    rst = 1'b1;
    #1;
    chk("mrst_state", 32'(sched_state), 32'd0);
    chk("mrst_wr_idx", 32'(wr_buf_idx), 32'd0);
    chk("mrst_rd_idx", 32'(rd_buf_idx), 32'd2);
    chk("mrst_drop", 32'(drop_count), 32'd0);
    chk("mrst_rd_addr", rd_base_addr, 32'h0104_B000);
    tick();
    rst = 1'b0;
    wr_idle = 1'b1;
    tick();
    tick();
    chk("mrst_after_idx", 32'(wr_buf_idx), 32'd0);
    chk("mrst_after_st", 32'(sched_state), 32'd1);
`else
    pulse_done();
    chk("db_wr_idx", 32'(wr_buf_idx), 32'd0);
    chk("db_drop", 32'(drop_count), 32'd1);
    chk("db_ready", 32'(frame_ready), 32'd1);
    chk("db_state", 32'(sched_state), 32'd1);

    rd_vsync = 1'b1;
    tick();
    rd_vsync = 1'b0;
    chk("db_vs_rd_idx", 32'(rd_buf_idx), 32'd1);
    tick();
    chk("db_vs_rd_addr", rd_base_addr, 32'h0102_5800);
    chk("db_wr_addr", wr_base_addr, 32'h0100_0000);

    wr_idle = 1'b0;
    pulse_done();
    chk("db_busy_state", 32'(sched_state), 32'd1);
    chk("db_busy_drop", 32'(drop_count), 32'd2);

    wr_idle = 1'b1;
    enable = 1'b0;
    tick();
    chk("db_dis_state", 32'(sched_state), 32'd0);
    pulse_done();
    chk("db_dis_drop", 32'(drop_count), 32'd2);

    rst = 1'b1;
    #1;
    chk("db_mrst_drop", 32'(drop_count), 32'd0);
    chk("db_mrst_ready", 32'(frame_ready), 32'd0);
    chk("db_mrst_state", 32'(sched_state), 32'd0);
    tick();
    rst = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
